rtc_hms_timer: RTL and testbench
================================

# rtc_hms_timer

Parametrised real-time clock/timer core: divides the system clock to a 1 Hz tick and maintains hours:minutes:seconds. It supports count-up (wall clock) and count-down (timer) modes, parallel time load, a one-shot alarm compare and start/stop control. It replaces the fixed 125 MHz second/minute counter as the time base for the display and control logic.

## Interface
Parameters:
- CLK_HZ, 125_000_000, input clock frequency; prescaler modulus (≥2). Benches use 10.
- HOURS, 24, hour modulus (2..32).
- Derived localparam: PRE_W = clog2(CLK_HZ).

Ports:
- clk_125MHz  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  level, sampled each edge; sets run state.
- stop  in  1  level, sampled each edge; clears run state; wins over start.
- mode  in  1  0 = count up, 1 = count down.
- load  in  1  loads ld_hh/ld_mm/ld_ss and clears the prescaler.
- ld_hh, ld_mm, ld_ss  in  5/6/6  load value.
- alarm_en  in  1  enables the alarm compare.
- al_hh, al_mm, al_ss  in  5/6/6  alarm time.
- hh, mm, ss  out  5/6/6  current time, registered.
- tick_1hz  out  1  one-cycle pulse per elapsed second.
- running  out  1  run state.
- done  out  1  one-cycle pulse when a countdown reaches 00:00:00.
- alarm  out  1  one-cycle pulse on alarm match.
- prescale  out  PRE_W  prescaler count, for debug.

## Operation
- Reset (rst=0 at edge): hh=mm=ss=0, prescale=0, running=0; tick_1hz, done and alarm all 0. Reset overrides every other input.
- Run control:
  - stop=1 → running←0.
  - else start=1 → running←1.
  - start while already running: no effect.
- Prescaler advances only when the registered running=1:
  - prescale==CLK_HZ-1 → prescale←0 and a tick occurs.
  - otherwise prescale←prescale+1.
  - Stop freezes prescale; it is not cleared, so pause/resume preserves the fractional second.
- Tick, count up (mode=0): ss+1. 59 wraps to 0 and carries to mm. mm 59 wraps to 0 and carries to hh. hh HOURS-1 wraps to 0. No done pulse.
- Tick, count down (mode=1): ss-1 with borrow chain (ss 0→59 borrows mm; mm 0→59 borrows hh).
  - Time reaching 00:00:00 → done=1, running←0.
  - Tick while already at 00:00:00 → time stays 0, done=1, running←0. Never underflows.
- mode is sampled at each tick; a change while running takes effect on the next tick.
- Load:
  - load=1 → time←ld_*, prescale←0, no tick that cycle. Load beats a coincident tick.
  - Out-of-range values clamp: ss/mm > 59 → 59; hh ≥ HOURS → HOURS-1.
  - running is unchanged by load.
  - load together with start: both apply.
- Alarm: alarm=1 on a tick edge when alarm_en=1 and the updated time equals al_*. Loads never raise alarm. A done tick can also raise alarm if al_* is 0.
- tick_1hz, done and alarm are registered single-cycle pulses, asserted in the same cycle the new time is visible.

## Timing
- start sampled at edge n → running=1 after edge n → first tick_1hz high after edge n+CLK_HZ. Period thereafter is exactly CLK_HZ cycles.
- Resume after stop at prescale=p → next tick after CLK_HZ-p further running edges.
- Load latency: 1 cycle (hh/mm/ss valid after the load edge).
- done/alarm latency: 0 cycles relative to tick_1hz. running drops in the same cycle done is high.
- No combinational input-to-output paths.

## Test plan
- Reset/run, CLK_HZ=10: rst=0 for 3 cycles, then start pulse → all outputs 0 during reset. First tick_1hz comes 10 cycles after the start edge; ss=1; ticks every 10 cycles.
- Up wrap, HOURS=24: load 23:59:58, start → after 2 ticks reads 00:00:00, no done; the 60-tick minute carry is also correct.
- Countdown: mode=1, load 00:01:01, start → 00:01:00, then 00:00:59, … 00:00:00 on tick 61 with done=1 and running=0. No further ticks. Restart at 0 → done again, time stays 0.
- Pause: stop at prescale=4, hold 50 cycles, start → next tick exactly 6 running cycles later; ss advances by 1 only.
- Alarm: alarm_en=1, al=00:00:05, load 0, start → alarm pulses with the 5th tick only. alarm_en=0 → no pulse. Loading 00:00:05 → no pulse.
- Priority/clamp: start+stop same cycle → running stays 0. load with tick-due prescale → loaded value, no tick. ld_ss=63, ld_hh=31 → ss=59, hh=23.

Source files
------------

// File: rtl/rtc_hms_timer.sv
// Real-time clock/timer core: divides clk_125MHz down to a 1 Hz tick and keeps
// hh:mm:ss, counting up (wall clock) or down (timer), with load and one-shot alarm.
module rtc_hms_timer #(
    parameter int  CLK_HZ = 125_000_000,
    parameter int  HOURS  = 24,
    localparam int PRE_W  = $clog2(CLK_HZ)
) (
    input  logic             clk_125MHz,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             load,
    input  logic [4:0]       ld_hh,
    input  logic [5:0]       ld_mm,
    input  logic [5:0]       ld_ss,
    input  logic             alarm_en,
    input  logic [4:0]       al_hh,
    input  logic [5:0]       al_mm,
    input  logic [5:0]       al_ss,
    output logic [4:0]       hh,
    output logic [5:0]       mm,
    output logic [5:0]       ss,
    output logic             tick_1hz,
    output logic             running,
    output logic             done,
    output logic             alarm,
    output logic [PRE_W-1:0] prescale
);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
    localparam logic [4:0]       HH_MAX  = 5'(HOURS - 1);

    logic [4:0]       hh_reg, hh_next, ld_hh_clamp;
    logic [5:0]       mm_reg, mm_next, ld_mm_clamp;
    logic [5:0]       ss_reg, ss_next, ld_ss_clamp;
    logic [PRE_W-1:0] prescale_reg;
    logic             running_reg, run_next;
    logic             tick_reg, done_reg, alarm_reg;
    logic             at_zero, next_zero, pre_wrap, alarm_hit;

    assign hh       = hh_reg;
    assign mm       = mm_reg;
    assign ss       = ss_reg;
    assign prescale = prescale_reg;
    assign running  = running_reg;
    assign tick_1hz = tick_reg;
    assign done     = done_reg;
    assign alarm    = alarm_reg;

    assign ld_ss_clamp = (ld_ss > 6'd59) ? 6'd59 : ld_ss;
    assign ld_mm_clamp = (ld_mm > 6'd59) ? 6'd59 : ld_mm;
    assign ld_hh_clamp = (32'(ld_hh) >= HOURS) ? HH_MAX : ld_hh;

    assign run_next = stop ? 1'b0 : (start ? 1'b1 : running_reg);
    assign pre_wrap = (prescale_reg == PRE_MAX);
    assign at_zero  = (hh_reg == 5'd0) && (mm_reg == 6'd0) && (ss_reg == 6'd0);

    // Time after the next tick; a countdown parked at zero stays at zero.
    always_comb begin
        hh_next = hh_reg;
        mm_next = mm_reg;
        ss_next = ss_reg;
        if (!mode) begin
            if (ss_reg == 6'd59) begin
                ss_next = 6'd0;
                if (mm_reg == 6'd59) begin
                    mm_next = 6'd0;
                    hh_next = (hh_reg == HH_MAX) ? 5'd0 : hh_reg + 5'd1;
                end else begin
                    mm_next = mm_reg + 6'd1;
                end
            end else begin
                ss_next = ss_reg + 6'd1;
            end
        end else if (!at_zero) begin
            if (ss_reg == 6'd0) begin
                ss_next = 6'd59;
                if (mm_reg == 6'd0) begin
                    mm_next = 6'd59;
                    hh_next = hh_reg - 5'd1;
                end else begin
                    mm_next = mm_reg - 6'd1;
                end
            end else begin
                ss_next = ss_reg - 6'd1;
            end
        end
    end

    assign next_zero = (hh_next == 5'd0) && (mm_next == 6'd0) && (ss_next == 6'd0);
    assign alarm_hit = alarm_en && (hh_next == al_hh) && (mm_next == al_mm) && (ss_next == al_ss);

    always_ff @(posedge clk_125MHz) begin
        if (!rst) begin
            hh_reg       <= 5'd0;
            mm_reg       <= 6'd0;
            ss_reg       <= 6'd0;
            prescale_reg <= '0;
            running_reg  <= 1'b0;
            tick_reg     <= 1'b0;
            done_reg     <= 1'b0;
            alarm_reg    <= 1'b0;
        end else begin
            tick_reg    <= 1'b0;
            done_reg    <= 1'b0;
            alarm_reg   <= 1'b0;
            running_reg <= run_next;
            if (load) begin
                // Load wins over a tick that would have fired this edge.
                hh_reg       <= ld_hh_clamp;
                mm_reg       <= ld_mm_clamp;
                ss_reg       <= ld_ss_clamp;
                prescale_reg <= '0;
            end else if (running_reg) begin
                if (pre_wrap) begin
                    prescale_reg <= '0;
                    hh_reg       <= hh_next;
                    mm_reg       <= mm_next;
                    ss_reg       <= ss_next;
                    tick_reg     <= 1'b1;
                    alarm_reg    <= alarm_hit;
                    if (mode && next_zero) begin
                        done_reg    <= 1'b1;
                        running_reg <= 1'b0;
                    end
                end else begin
                    prescale_reg <= prescale_reg + PRE_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_rtc_hms_timer.sv
// Self-checking bench for rtc_hms_timer with a 10-cycle second: expected output
// records are queued when stimulus is driven and compared once the DUT responds.
module tb_rtc_hms_timer;
    localparam int CLK_HZ = 10;
    localparam int HOURS  = 24;
    localparam int PRE_W  = $clog2(CLK_HZ);

    logic             clk_125MHz = 1'b0;
    logic             rst, start, stop, mode, load, alarm_en;
    logic [4:0]       ld_hh, al_hh, hh;
    logic [5:0]       ld_mm, ld_ss, al_mm, al_ss, mm, ss;
    logic             tick_1hz, running, done, alarm;
    logic [PRE_W-1:0] prescale;

    always #5 clk_125MHz = ~clk_125MHz;

    rtc_hms_timer #(.CLK_HZ(CLK_HZ), .HOURS(HOURS)) dut (
        .clk_125MHz(clk_125MHz), .rst(rst), .start(start), .stop(stop),
        .mode(mode), .load(load), .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
        .alarm_en(alarm_en), .al_hh(al_hh), .al_mm(al_mm), .al_ss(al_ss),
        .hh(hh), .mm(mm), .ss(ss), .tick_1hz(tick_1hz), .running(running),
        .done(done), .alarm(alarm), .prescale(prescale)
    );

    typedef struct {
        string name;
        int    hh, mm, ss;
        bit    tick, done, alarm, running;
        int    pre;   // negative means prescale is not checked
    } exp_t;

    typedef struct {
        int ld_hh, ld_mm, ld_ss;
        int hh, mm, ss;
    } ld_vec_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic step();
        @(posedge clk_125MHz);
        #1;
    endtask

    task automatic expect_out(input string name, input int h, input int m, input int s,
                              input bit t, input bit d, input bit a, input bit r, input int pre);
        exp_t e;
        e.name = name; e.hh = h; e.mm = m; e.ss = s;
        e.tick = t; e.done = d; e.alarm = a; e.running = r; e.pre = pre;
        exp_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        bit   ok;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got no expected record, want one queued");
            return;
        end
        e  = exp_q.pop_front();
        ok = (int'(hh) == e.hh) && (int'(mm) == e.mm) && (int'(ss) == e.ss) &&
             (tick_1hz == e.tick) && (done == e.done) && (alarm == e.alarm) &&
             (running == e.running) && (e.pre < 0 || int'(prescale) == e.pre);
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d:%0d:%0d tick=%0b done=%0b alarm=%0b run=%0b pre=%0d, want %0d:%0d:%0d tick=%0b done=%0b alarm=%0b run=%0b pre=%0d",
                     e.name, hh, mm, ss, tick_1hz, done, alarm, running, prescale,
                     e.hh, e.mm, e.ss, e.tick, e.done, e.alarm, e.running, e.pre);
        end else begin
            $display("pass %s time=%0d:%0d:%0d tick=%0b done=%0b alarm=%0b run=%0b pre=%0d",
                     e.name, hh, mm, ss, tick_1hz, done, alarm, running, prescale);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end else begin
            $display("pass %s = %0d", name, got);
        end
    endtask

    // Steps until tick_1hz is seen, giving up after 40 cycles.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick_1hz !== 1'b1 && n < 40);
    endtask

    task automatic hold(input int cyc, output int ticks);
        ticks = 0;
        repeat (cyc) begin
            step();
            if (tick_1hz) ticks++;
        end
    endtask

    task automatic set_load(input int h, input int m, input int s);
        ld_hh = 5'(h); ld_mm = 6'(m); ld_ss = 6'(s);
        load  = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish within time limit, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ld_vec_t vecs[6];
        int      n, t, rem;

        vecs[0] = '{12, 34, 56, 12, 34, 56};
        vecs[1] = '{31, 63, 63, 23, 59, 59};
        vecs[2] = '{24, 60, 60, 23, 59, 59};
        vecs[3] = '{23, 59, 59, 23, 59, 59};
        vecs[4] = '{ 5, 61,  7,  5, 59,  7};
        vecs[5] = '{ 0,  0,  0,  0,  0,  0};

        // Reset held with every other input active: outputs must stay zero.
        rst = 1'b0; start = 1'b1; stop = 1'b0; mode = 1'b0; alarm_en = 1'b1;
        al_hh = '0; al_mm = '0; al_ss = '0;
        set_load(12, 34, 56);
        for (int i = 0; i < 3; i++) begin
            expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
            step();
            sb_check();
        end

        rst = 1'b1; load = 1'b0; alarm_en = 1'b0; start = 1'b1;
        expect_out("start", 0, 0, 0, 0, 0, 0, 1, 0);
        step(); sb_check();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            expect_out("up_tick", 0, 0, k, 1, 0, 0, 1, 0);
            wait_tick(n); sb_check();
            chk_int("tick_period", n, 10);
        end

        // Day wrap, then a full minute of ticks for the carry into mm.
        set_load(23, 59, 58);
        expect_out("load_2359", 23, 59, 58, 0, 0, 0, 1, 0);
        step(); sb_check();
        load = 1'b0;
        expect_out("up_235959", 23, 59, 59, 1, 0, 0, 1, 0);
        wait_tick(n); sb_check();
        expect_out("day_wrap", 0, 0, 0, 1, 0, 0, 1, 0);
        wait_tick(n); sb_check();
        for (int k = 1; k <= 60; k++) begin
            expect_out("minute_carry", 0, k / 60, k % 60, 1, 0, 0, 1, 0);
            wait_tick(n); sb_check();
        end
        chk_int("minute_period", n, 10);

        stop = 1'b1;
        expect_out("stop", 0, 1, 0, 0, 0, 0, 0, -1);
        step(); sb_check();
        stop = 1'b0;

        // Load/clamp table while stopped.
        for (int i = 0; i < 6; i++) begin
            set_load(vecs[i].ld_hh, vecs[i].ld_mm, vecs[i].ld_ss);
            expect_out($sformatf("load_vec%0d", i), vecs[i].hh, vecs[i].mm, vecs[i].ss, 0, 0, 0, 0, 0);
            step(); sb_check();
        end
        load = 1'b0;

        start = 1'b1; stop = 1'b1;
        expect_out("start_stop_same", 0, 0, 0, 0, 0, 0, 0, 0);
        step(); sb_check();
        stop = 1'b0;

        // Load beats a tick that is due on the same edge.
        set_load(0, 0, 0);
        expect_out("load_start", 0, 0, 0, 0, 0, 0, 1, 0);
        step(); sb_check();
        load = 1'b0; start = 1'b0;
        expect_out("pre_due", 0, 0, 0, 0, 0, 0, 1, 9);
        repeat (9) step();
        sb_check();
        set_load(10, 20, 30);
        expect_out("load_over_tick", 10, 20, 30, 0, 0, 0, 1, 0);
        step(); sb_check();
        load = 1'b0;
        expect_out("after_load_tick", 10, 20, 31, 1, 0, 0, 1, 0);
        wait_tick(n); sb_check();
        chk_int("after_load_period", n, 10);

        // Pause and resume keeps the fractional second.
        set_load(0, 0, 0);
        step();
        load = 1'b0;
        expect_out("pre3", 0, 0, 0, 0, 0, 0, 1, 3);
        repeat (3) step();
        sb_check();
        stop = 1'b1;
        expect_out("stop_pre4", 0, 0, 0, 0, 0, 0, 0, 4);
        step(); sb_check();
        stop = 1'b0;
        hold(50, t);
        chk_int("paused_ticks", t, 0);
        expect_out("paused", 0, 0, 0, 0, 0, 0, 0, 4);
        sb_check();
        start = 1'b1;
        expect_out("resume", 0, 0, 0, 0, 0, 0, 1, 4);
        step(); sb_check();
        start = 1'b0;
        expect_out("resume_tick", 0, 0, 1, 1, 0, 0, 1, 0);
        wait_tick(n); sb_check();
        chk_int("resume_latency", n, 6);
        expect_out("resume_next", 0, 0, 2, 1, 0, 0, 1, 0);
        wait_tick(n); sb_check();
        chk_int("resume_period", n, 10);

        // Alarm at 00:00:05 only; disabled alarm; load of the alarm time.
        alarm_en = 1'b1; al_hh = 5'd0; al_mm = 6'd0; al_ss = 6'd5;
        set_load(0, 0, 0);
        expect_out("alarm_load0", 0, 0, 0, 0, 0, 0, 1, 0);
        step(); sb_check();
        load = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            expect_out("alarm_tick", 0, 0, k, 1, 0, k == 5, 1, 0);
            wait_tick(n); sb_check();
        end
        alarm_en = 1'b0;
        set_load(0, 0, 0);
        step();
        load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            expect_out("alarm_off_tick", 0, 0, k, 1, 0, 0, 1, 0);
            wait_tick(n); sb_check();
        end
        alarm_en = 1'b1;
        set_load(0, 0, 5);
        expect_out("alarm_on_load", 0, 0, 5, 0, 0, 0, 1, 0);
        step(); sb_check();
        load = 1'b0; alarm_en = 1'b0;

        // Countdown from 00:01:01 to zero.
        stop = 1'b1;
        step();
        stop = 1'b0; mode = 1'b1; start = 1'b1;
        set_load(0, 1, 1);
        expect_out("down_load", 0, 1, 1, 0, 0, 0, 1, 0);
        step(); sb_check();
        load = 1'b0; start = 1'b0;
        for (int k = 1; k <= 61; k++) begin
            rem = 61 - k;
            expect_out("down_tick", rem / 3600, (rem / 60) % 60, rem % 60, 1, k == 61, 0, k != 61, 0);
            wait_tick(n); sb_check();
        end
        hold(30, t);
        chk_int("ticks_after_done", t, 0);
        expect_out("parked_zero", 0, 0, 0, 0, 0, 0, 0, 0);
        sb_check();
        start = 1'b1;
        expect_out("restart_zero", 0, 0, 0, 0, 0, 0, 1, 0);
        step(); sb_check();
        start = 1'b0;
        expect_out("done_at_zero", 0, 0, 0, 1, 1, 0, 0, 0);
        wait_tick(n); sb_check();
        chk_int("restart_latency", n, 10);

        // A done tick also raises alarm when the alarm time is zero.
        alarm_en = 1'b1; al_ss = 6'd0;
        set_load(0, 0, 1); start = 1'b1;
        expect_out("done_alarm_load", 0, 0, 1, 0, 0, 0, 1, 0);
        step(); sb_check();
        load = 1'b0; start = 1'b0;
        expect_out("done_alarm", 0, 0, 0, 1, 1, 1, 0, 0);
        wait_tick(n); sb_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
